// File: rtl/clks_alot_p.sv
// Shared constants for the clks_alot clock-generation blocks.
//   COUNTER_WIDTH : width of every rate, lead and offset field, in bits.
package clks_alot_p;
  localparam int COUNTER_WIDTH = 16;
endpackage

// File: rtl/generation_sequencer_if.sv
// Configuration request channel for generation_sequencer.
//   cfg_valid_i / cfg_ready_o : valid/ready handshake for one configuration
//   cfg_half_rate_i           : half period of the generated clock, in clk cycles
//   cfg_lead_i                : preemptive lead, in clk cycles
//   cfg_sync_offset_i         : recovery offset
//   cfg_starting_polarity_i   : polarity the generated clock starts with
//   cfg_reject_o              : one-cycle pulse when the captured configuration is invalid
// The slave modport is the sequencer; the master modport is the requester.
interface generation_sequencer_if #(
  parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH
);
  logic                     cfg_valid_i;
  logic                     cfg_ready_o;
  logic [COUNTER_WIDTH-1:0] cfg_half_rate_i;
  logic [COUNTER_WIDTH-1:0] cfg_lead_i;
  logic [COUNTER_WIDTH-1:0] cfg_sync_offset_i;
  logic                     cfg_starting_polarity_i;
  logic                     cfg_reject_o;

  modport slave (
    input  cfg_valid_i, cfg_half_rate_i, cfg_lead_i, cfg_sync_offset_i, cfg_starting_polarity_i,
    output cfg_ready_o, cfg_reject_o
  );

  modport master (
    output cfg_valid_i, cfg_half_rate_i, cfg_lead_i, cfg_sync_offset_i, cfg_starting_polarity_i,
    input  cfg_ready_o, cfg_reject_o
  );
endinterface

// File: rtl/generation_sequencer.sv
// generation_sequencer: owns configuration and run/stop/pause control of one
// clock generation instance.
//
// Build option: define GEN_SEQ_VIOLATION_COUNT_EN to keep a saturating count of
// pause-violation cycles; without it only the sticky flag exists and
// violation_count_o is tied to zero.
//
// Ports:
//   clk, rst_n (async, active-low), clk_en (qualifies every state update)
//   cfg                         : configuration channel (generation_sequencer_if.slave)
//   run_i                       : level request to run the generator
//   pause_req_i, pause_polarity_i : pause request and polarity to hold while paused
//   gen_busy_i                  : generator busy
//   pause_start/stop_violation_i: generator pause-violation flags
//   violation_clear_i           : clears sticky flag and counter
//   generation_en_o, set_polarity_o, starting_polarity_o : generator control
//   *_minus_one_o, sync_cycle_offset_o : applied compare values
//   pause_en_o, pause_polarity_o: pause control to the generator
//   configured_o, running_o     : status
//   violation_sticky_o, violation_count_o : violation reporting
module generation_sequencer #(
  parameter int COUNTER_WIDTH         = clks_alot_p::COUNTER_WIDTH,
  parameter int VIOLATION_COUNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clk_en,
  generation_sequencer_if.slave            cfg,
  input  logic                             run_i,
  input  logic                             pause_req_i,
  input  logic                             pause_polarity_i,
  input  logic                             gen_busy_i,
  input  logic                             pause_start_violation_i,
  input  logic                             pause_stop_violation_i,
  input  logic                             violation_clear_i,
  output logic                             generation_en_o,
  output logic                             set_polarity_o,
  output logic                             starting_polarity_o,
  output logic [COUNTER_WIDTH-1:0]         expected_half_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0]         expected_quarter_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0]         preemptive_half_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0]         preemptive_quarter_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0]         sync_cycle_offset_o,
  output logic                             pause_en_o,
  output logic                             pause_polarity_o,
  output logic                             configured_o,
  output logic                             running_o,
  output logic                             violation_sticky_o,
  output logic [VIOLATION_COUNT_WIDTH-1:0] violation_count_o
);
  localparam int CW = COUNTER_WIDTH;
  localparam int VW = VIOLATION_COUNT_WIDTH;

  localparam logic [CW:0]   ONE_W = (CW+1)'(1);
  localparam logic [CW:0]   TWO_W = (CW+1)'(2);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DRAIN = 3'd2,
    S_ARM   = 3'd3,
    S_RUN   = 3'd4
  } state_e;

  // Validity is evaluated one bit wider than the fields so lead + offset + 1
  // can never wrap.
  function automatic logic cfg_is_valid(input logic [CW-1:0] half,
                                        input logic [CW-1:0] lead,
                                        input logic [CW-1:0] offs);
    logic [CW:0] h_w;
    logic [CW:0] hh_w;
    logic [CW:0] l_w;
    logic [CW:0] o_w;
    h_w  = {1'b0, half};
    hh_w = {2'b00, half[CW-1:1]};
    l_w  = {1'b0, lead};
    o_w  = {1'b0, offs};
    return (h_w >= TWO_W) && (h_w >= l_w + o_w + ONE_W) && (hh_w >= l_w + ONE_W);
  endfunction

  state_e          state_q, state_d;
  logic            from_run_q, from_run_d;
  logic            pending_q, pending_d;
  logic            ready_q, ready_d;
  logic [CW-1:0]   sh_half_q, sh_half_d;
  logic [CW-1:0]   sh_lead_q, sh_lead_d;
  logic [CW-1:0]   sh_offs_q, sh_offs_d;
  logic            sh_pol_q, sh_pol_d;
  logic [CW-1:0]   exp_half_q, exp_half_d;
  logic [CW-1:0]   exp_quar_q, exp_quar_d;
  logic [CW-1:0]   pre_half_q, pre_half_d;
  logic [CW-1:0]   pre_quar_q, pre_quar_d;
  logic [CW-1:0]   offs_q, offs_d;
  logic            start_pol_q, start_pol_d;
  logic            configured_q, configured_d;
  logic            pause_en_q, pause_en_d;
  logic            pause_pol_q, pause_pol_d;
  logic            sticky_q, sticky_d;

  logic            handshake;
  logic            cfg_ok;
  logic            load;
  logic            violation_evt;
  logic [CW-1:0]   half_of_half;

  assign handshake     = cfg.cfg_valid_i && ready_q;
  assign cfg_ok        = cfg_is_valid(sh_half_q, sh_lead_q, sh_offs_q);
  assign violation_evt = pause_start_violation_i || pause_stop_violation_i;
  assign half_of_half  = {1'b0, sh_half_q[CW-1:1]};

  always_comb begin
    state_d      = state_q;
    from_run_d   = from_run_q;
    pending_d    = pending_q;
    sh_half_d    = sh_half_q;
    sh_lead_d    = sh_lead_q;
    sh_offs_d    = sh_offs_q;
    sh_pol_d     = sh_pol_q;
    exp_half_d   = exp_half_q;
    exp_quar_d   = exp_quar_q;
    pre_half_d   = pre_half_q;
    pre_quar_d   = pre_quar_q;
    offs_d       = offs_q;
    start_pol_d  = start_pol_q;
    configured_d = configured_q;
    load         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d    = S_CHECK;
          from_run_d = 1'b0;
        end else if (configured_q && run_i && !gen_busy_i) begin
          state_d = S_RUN;
        end
      end
      S_CHECK: begin
        if (!cfg_ok) begin
          state_d = from_run_q ? S_RUN : S_IDLE;
        end else if (from_run_q) begin
          state_d   = S_DRAIN;
          pending_d = 1'b1;
        end else begin
          state_d = S_ARM;
          load    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!gen_busy_i) begin
          if (pending_q) begin
            state_d   = S_ARM;
            pending_d = 1'b0;
            load      = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ARM: begin
        state_d = run_i ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (handshake) begin
          state_d    = S_CHECK;
          from_run_d = 1'b1;
        end else if (!run_i) begin
          state_d   = S_DRAIN;
          pending_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (handshake) begin
      sh_half_d = cfg.cfg_half_rate_i;
      sh_lead_d = cfg.cfg_lead_i;
      sh_offs_d = cfg.cfg_sync_offset_i;
      sh_pol_d  = cfg.cfg_starting_polarity_i;
    end

    // Applied values only change on entry to ARM, i.e. with the generator idle.
    if (load) begin
      exp_half_d   = sh_half_q - ONE_C;
      exp_quar_d   = half_of_half - ONE_C;
      pre_half_d   = sh_half_q - sh_lead_q - ONE_C;
      pre_quar_d   = half_of_half - sh_lead_q - ONE_C;
      offs_d       = sh_offs_q;
      start_pol_d  = sh_pol_q;
      configured_d = 1'b1;
    end

    ready_d     = (state_d == S_IDLE) || (state_d == S_RUN);
    pause_en_d  = (state_d == S_RUN) && pause_req_i;
    // Polarity is frozen for the whole pause once pause_en is up.
    pause_pol_d = pause_en_q ? pause_pol_q : pause_polarity_i;

    // A new violation outranks a simultaneous clear.
    if (violation_evt) begin
      sticky_d = 1'b1;
    end else if (violation_clear_i) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      from_run_q   <= 1'b0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b0;
      sh_half_q    <= '0;
      sh_lead_q    <= '0;
      sh_offs_q    <= '0;
      sh_pol_q     <= 1'b0;
      exp_half_q   <= '0;
      exp_quar_q   <= '0;
      pre_half_q   <= '0;
      pre_quar_q   <= '0;
      offs_q       <= '0;
      start_pol_q  <= 1'b0;
      configured_q <= 1'b0;
      pause_en_q   <= 1'b0;
      pause_pol_q  <= 1'b0;
      sticky_q     <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      from_run_q   <= from_run_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
      sh_half_q    <= sh_half_d;
      sh_lead_q    <= sh_lead_d;
      sh_offs_q    <= sh_offs_d;
      sh_pol_q     <= sh_pol_d;
      exp_half_q   <= exp_half_d;
      exp_quar_q   <= exp_quar_d;
      pre_half_q   <= pre_half_d;
      pre_quar_q   <= pre_quar_d;
      offs_q       <= offs_d;
      start_pol_q  <= start_pol_d;
      configured_q <= configured_d;
      pause_en_q   <= pause_en_d;
      pause_pol_q  <= pause_pol_d;
      sticky_q     <= sticky_d;
    end
  end

`ifdef GEN_SEQ_VIOLATION_COUNT_EN
  localparam logic [VW-1:0] CNT_ONE = VW'(1);

  function automatic logic [VW-1:0] sat_inc(input logic [VW-1:0] val);
    return (&val) ? val : val + CNT_ONE;
  endfunction

  logic [VW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (violation_evt) begin
      count_d = violation_clear_i ? CNT_ONE : sat_inc(count_q);
    end else if (violation_clear_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clk_en) begin
      count_q <= count_d;
    end
  end

  assign violation_count_o = count_q;
`else
  assign violation_count_o = '0;
`endif

  assign cfg.cfg_ready_o  = ready_q;
  // Pulses are decoded from state so a frozen clk_en holds them asserted.
  assign cfg.cfg_reject_o = (state_q == S_CHECK) && !cfg_ok;
  assign set_polarity_o   = (state_q == S_ARM);
  assign generation_en_o  = (state_q == S_RUN);
  assign running_o        = (state_q == S_RUN);

  assign starting_polarity_o                 = start_pol_q;
  assign expected_half_rate_minus_one_o      = exp_half_q;
  assign expected_quarter_rate_minus_one_o   = exp_quar_q;
  assign preemptive_half_rate_minus_one_o    = pre_half_q;
  assign preemptive_quarter_rate_minus_one_o = pre_quar_q;
  assign sync_cycle_offset_o                 = offs_q;
  assign configured_o                        = configured_q;
  assign pause_en_o                          = pause_en_q;
  assign pause_polarity_o                    = pause_pol_q;
  assign violation_sticky_o                  = sticky_q;
endmodule

// File: tb/tb_generation_sequencer.sv
// Directed self-checking bench for generation_sequencer.
module tb_generation_sequencer;
  localparam int CW = 16;
  localparam int VW = 8;

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic          run_i;
  logic          pause_req_i;
  logic          pause_polarity_i;
  logic          gen_busy_i;
  logic          start_viol;
  logic          stop_viol;
  logic          viol_clear;
  logic          generation_en_o;
  logic          set_polarity_o;
  logic          starting_polarity_o;
  logic [CW-1:0] exp_half;
  logic [CW-1:0] exp_quar;
  logic [CW-1:0] pre_half;
  logic [CW-1:0] pre_quar;
  logic [CW-1:0] sync_off;
  logic          pause_en_o;
  logic          pause_polarity_o;
  logic          configured_o;
  logic          running_o;
  logic          sticky_o;
  logic [VW-1:0] count_o;

  int n_cmp = 0;
  int n_err = 0;

  generation_sequencer_if #(.COUNTER_WIDTH(CW)) cfg_if ();

  generation_sequencer #(
    .COUNTER_WIDTH(CW),
    .VIOLATION_COUNT_WIDTH(VW)
  ) dut (
    .clk                                 (clk),
    .rst_n                               (rst_n),
    .clk_en                              (clk_en),
    .cfg                                 (cfg_if),
    .run_i                               (run_i),
    .pause_req_i                         (pause_req_i),
    .pause_polarity_i                    (pause_polarity_i),
    .gen_busy_i                          (gen_busy_i),
    .pause_start_violation_i             (start_viol),
    .pause_stop_violation_i              (stop_viol),
    .violation_clear_i                   (viol_clear),
    .generation_en_o                     (generation_en_o),
    .set_polarity_o                      (set_polarity_o),
    .starting_polarity_o                 (starting_polarity_o),
    .expected_half_rate_minus_one_o      (exp_half),
    .expected_quarter_rate_minus_one_o   (exp_quar),
    .preemptive_half_rate_minus_one_o    (pre_half),
    .preemptive_quarter_rate_minus_one_o (pre_quar),
    .sync_cycle_offset_o                 (sync_off),
    .pause_en_o                          (pause_en_o),
    .pause_polarity_o                    (pause_polarity_o),
    .configured_o                        (configured_o),
    .running_o                           (running_o),
    .violation_sticky_o                  (sticky_o),
    .violation_count_o                   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int half, input int lead, input int offs, input logic pol);
    cfg_if.cfg_half_rate_i         = CW'(half);
    cfg_if.cfg_lead_i              = CW'(lead);
    cfg_if.cfg_sync_offset_i       = CW'(offs);
    cfg_if.cfg_starting_polarity_i = pol;
  endtask

  task automatic send_cfg(input int half, input int lead, input int offs, input logic pol);
    set_cfg(half, lead, offs, pol);
    cfg_if.cfg_valid_i = 1'b1;
    tick();
    cfg_if.cfg_valid_i = 1'b0;
  endtask

  task automatic check_rates(input string tag, input int eh, input int eq, input int ph,
                             input int pq, input int of);
    check_val({tag, "_exp_half"}, 32'(exp_half), eh);
    check_val({tag, "_exp_quar"}, 32'(exp_quar), eq);
    check_val({tag, "_pre_half"}, 32'(pre_half), ph);
    check_val({tag, "_pre_quar"}, 32'(pre_quar), pq);
    check_val({tag, "_offset"},   32'(sync_off), of);
  endtask

  initial begin
    int cnt_on;
`ifdef GEN_SEQ_VIOLATION_COUNT_EN
    cnt_on = 1;
`else
    cnt_on = 0;
`endif
    rst_n            = 1'b0;
    clk_en           = 1'b1;
    run_i            = 1'b0;
    pause_req_i      = 1'b0;
    pause_polarity_i = 1'b0;
    gen_busy_i       = 1'b0;
    start_viol       = 1'b0;
    stop_viol        = 1'b0;
    viol_clear       = 1'b0;
    cfg_if.cfg_valid_i = 1'b0;
    set_cfg(0, 0, 0, 1'b0);
    repeat (2) tick();

    // Reset state
    check_val("rst_ready",      32'(cfg_if.cfg_ready_o), 0);
    check_val("rst_gen_en",     32'(generation_en_o), 0);
    check_val("rst_set_pol",    32'(set_polarity_o), 0);
    check_val("rst_configured", 32'(configured_o), 0);
    check_val("rst_count",      32'(count_o), 0);
    check_val("rst_sticky",     32'(sticky_o), 0);
    check_rates("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_val("idle_ready", 32'(cfg_if.cfg_ready_o), 1);

    // Valid configuration from IDLE with run requested
    run_i = 1'b1;
    send_cfg(20, 5, 4, 1'b1);
    check_val("chk_reject",  32'(cfg_if.cfg_reject_o), 0);
    check_val("chk_ready",   32'(cfg_if.cfg_ready_o), 0);
    check_val("chk_set_pol", 32'(set_polarity_o), 0);
    check_val("chk_old_half", 32'(exp_half), 0);
    tick();
    check_val("arm_set_pol",    32'(set_polarity_o), 1);
    check_val("arm_configured", 32'(configured_o), 1);
    check_val("arm_gen_en",     32'(generation_en_o), 0);
    check_val("arm_start_pol",  32'(starting_polarity_o), 1);
    check_rates("cfg20", 19, 9, 14, 4, 4);
    tick();
    check_val("run_gen_en",  32'(generation_en_o), 1);
    check_val("run_running", 32'(running_o), 1);
    check_val("run_set_pol", 32'(set_polarity_o), 0);

    // Invalid configuration from RUN
    send_cfg(9, 5, 4, 1'b0);
    check_val("rej_run_pulse", 32'(cfg_if.cfg_reject_o), 1);
    tick();
    check_val("rej_run_clear",   32'(cfg_if.cfg_reject_o), 0);
    check_val("rej_run_running", 32'(running_o), 1);
    check_val("rej_run_half",    32'(exp_half), 19);
    check_val("rej_run_pol",     32'(starting_polarity_o), 1);

    // Pause in RUN, polarity flipped mid-pause
    pause_polarity_i = 1'b1;
    pause_req_i      = 1'b1;
    check_val("pause_late", 32'(pause_en_o), 0);
    tick();
    check_val("pause_on",  32'(pause_en_o), 1);
    check_val("pause_pol", 32'(pause_polarity_o), 1);
    pause_polarity_i = 1'b0;
    tick();
    check_val("pause_hold_en",  32'(pause_en_o), 1);
    check_val("pause_hold_pol", 32'(pause_polarity_o), 1);
    pause_req_i = 1'b0;
    tick();
    check_val("pause_off",     32'(pause_en_o), 0);
    check_val("pause_off_pol", 32'(pause_polarity_o), 1);
    tick();
    check_val("pause_recap", 32'(pause_polarity_o), 0);

    // Reconfigure in RUN with generator busy for 6 cycles after enable drops
    gen_busy_i = 1'b1;
    send_cfg(40, 3, 2, 1'b0);
    check_val("recfg_chk_en", 32'(generation_en_o), 0);
    repeat (5) tick();
    check_val("drain_en",      32'(generation_en_o), 0);
    check_val("drain_set_pol", 32'(set_polarity_o), 0);
    check_val("drain_half",    32'(exp_half), 19);
    check_val("drain_pre_q",   32'(pre_quar), 4);
    gen_busy_i = 1'b0;
    tick();
    check_val("recfg_arm",  32'(set_polarity_o), 1);
    check_val("recfg_pol",  32'(starting_polarity_o), 0);
    check_rates("cfg40", 39, 19, 36, 16, 2);
    tick();
    check_val("recfg_run", 32'(generation_en_o), 1);

    // Stop, then invalid configuration and pause request in IDLE
    run_i = 1'b0;
    tick();
    tick();
    check_val("stop_running", 32'(running_o), 0);
    check_val("stop_ready",   32'(cfg_if.cfg_ready_o), 1);
    pause_req_i = 1'b1;
    tick();
    tick();
    check_val("idle_pause", 32'(pause_en_o), 0);
    pause_req_i = 1'b0;
    send_cfg(9, 5, 4, 1'b1);
    check_val("rej_idle_pulse", 32'(cfg_if.cfg_reject_o), 1);
    tick();
    check_val("rej_idle_clear", 32'(cfg_if.cfg_reject_o), 0);
    check_val("rej_idle_ready", 32'(cfg_if.cfg_ready_o), 1);
    check_val("rej_idle_en",    32'(generation_en_o), 0);
    check_val("rej_idle_half",  32'(exp_half), 39);

    // Violations: both flags together count once, then saturate
    start_viol = 1'b1;
    stop_viol  = 1'b1;
    repeat (3) tick();
    check_val("viol_both",   32'(count_o), cnt_on * 3);
    check_val("viol_sticky", 32'(sticky_o), 1);
    stop_viol = 1'b0;
    repeat (297) tick();
    check_val("viol_sat", 32'(count_o), cnt_on * 255);
    viol_clear = 1'b1;
    tick();
    check_val("clr_evt_count",  32'(count_o), cnt_on);
    check_val("clr_evt_sticky", 32'(sticky_o), 1);
    start_viol = 1'b0;
    tick();
    check_val("clr_count",  32'(count_o), 0);
    check_val("clr_sticky", 32'(sticky_o), 0);
    viol_clear = 1'b0;

    // Asynchronous reset during DRAIN
    run_i = 1'b1;
    tick();
    check_val("rerun", 32'(running_o), 1);
    gen_busy_i = 1'b1;
    run_i      = 1'b0;
    tick();
    check_val("drain2_en", 32'(generation_en_o), 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstd_configured", 32'(configured_o), 0);
    check_val("rstd_ready",      32'(cfg_if.cfg_ready_o), 0);
    check_rates("rstd", 0, 0, 0, 0, 0);
    tick();
    rst_n      = 1'b1;
    gen_busy_i = 1'b0;
    tick();

    // Asynchronous reset during ARM
    send_cfg(20, 5, 4, 1'b1);
    tick();
    check_val("arm2_set_pol", 32'(set_polarity_o), 1);
    check_val("arm2_pol",     32'(starting_polarity_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rsta_set_pol",    32'(set_polarity_o), 0);
    check_val("rsta_configured", 32'(configured_o), 0);
    check_val("rsta_pol",        32'(starting_polarity_o), 0);
    check_val("rsta_half",       32'(exp_half), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Minimum legal half rate, with clk_en freezing the ARM pulse
    send_cfg(2, 0, 0, 1'b1);
    tick();
    check_val("min_set_pol", 32'(set_polarity_o), 1);
    check_rates("min", 1, 0, 1, 0, 0);
    clk_en = 1'b0;
    repeat (2) tick();
    check_val("frz_set_pol", 32'(set_polarity_o), 1);
    clk_en = 1'b1;
    tick();
    check_val("unfrz_set_pol",    32'(set_polarity_o), 0);
    check_val("unfrz_configured", 32'(configured_o), 1);

    // Half rate below 2 is rejected
    send_cfg(1, 0, 0, 1'b0);
    check_val("half1_reject", 32'(cfg_if.cfg_reject_o), 1);
    tick();
    check_val("half1_keep", 32'(exp_half), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/generation_sequencer.md
# generation_sequencer

Control-plane sequencer that owns the configuration and run/stop/pause control of one clock `generation` instance. It accepts rate-configuration requests over a valid/ready handshake and validates them against the generator's minimum-rate constraints. It derives the four `*_minus_one` compare values and applies them only while the generator is idle, restarting it phase-correctly with a `set_polarity` pulse. It also gates pause requests and accumulates pause-violation reports.

## Interface
- `COUNTER_WIDTH`, `clks_alot_p::COUNTER_WIDTH`: width of all rate, lead and offset fields (CW).
- `VIOLATION_COUNT_WIDTH`, 8: width of the violation counter (VW).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: all state updates are qualified by it.
- `cfg_valid_i` in 1, `cfg_ready_o` out 1: configuration handshake.
- `cfg_half_rate_i` in CW: half period, in clk cycles.
- `cfg_lead_i` in CW: preemptive lead, in cycles.
- `cfg_sync_offset_i` in CW: recovery offset.
- `cfg_starting_polarity_i` in 1: starting polarity of the generated clock.
- `cfg_reject_o` out 1: one-cycle pulse when a configuration is invalid.
- `run_i` in 1: level request to run the generator.
- `pause_req_i` in 1: pause request.
- `pause_polarity_i` in 1: polarity to hold during a pause.
- `gen_busy_i` in 1: generator `busy_o`.
- `pause_start_violation_i`, `pause_stop_violation_i` in 1: generator pause-violation flags.
- `generation_en_o` out 1: generator enable.
- `set_polarity_o` out 1: one-cycle polarity-set pulse.
- `starting_polarity_o` out 1: applied starting polarity.
- `expected_half_rate_minus_one_o`, `expected_quarter_rate_minus_one_o`, `preemptive_half_rate_minus_one_o`, `preemptive_quarter_rate_minus_one_o`, `sync_cycle_offset_o` out CW: applied configuration.
- `pause_en_o`, `pause_polarity_o` out 1: pause control to the generator.
- `configured_o`, `running_o` out 1: status.
- `violation_sticky_o` out 1, `violation_count_o` out VW, `violation_clear_i` in 1: violation reporting.

## Operation
- States: IDLE, CHECK, DRAIN, ARM, RUN. Reset state is IDLE.
- All outputs are 0 in reset. This includes `configured_o`, the rate outputs and the counters.
- `cfg_ready_o` is high only in IDLE and RUN.
- A handshake captures all `cfg_*` fields into a shadow register and moves the FSM to CHECK.
- The field is valid iff all of the following hold (comparisons in CW+1 bits, no overflow):
  - half ≥ 2
  - half ≥ lead + sync_offset + 1
  - (half>>1) ≥ lead + 1
- CHECK, invalid: `cfg_reject_o`=1 for that cycle. The FSM returns to the state it came from (IDLE or RUN). The applied configuration is unchanged.
- CHECK, valid, came from RUN: go to DRAIN with `pending_load`=1.
- CHECK, valid, came from IDLE: go to ARM.
- Applied values are loaded on the CHECK→ARM edge, or on the DRAIN→ARM edge:
  - expected half = half−1
  - expected quarter = (half>>1)−1
  - preemptive half = half−lead−1
  - preemptive quarter = (half>>1)−lead−1
  - offset = sync_offset
  - starting polarity = captured value
- DRAIN: `generation_en_o`=0. Wait for `gen_busy_i`=0. Then go to ARM if `pending_load`, else to IDLE.
- ARM: `set_polarity_o`=1 for exactly one cycle and `configured_o` is set. The next state is RUN if `run_i`, else IDLE.
- IDLE → RUN when `configured_o` && `run_i` && !`gen_busy_i`.
- RUN: `generation_en_o`=1 and `running_o`=1. RUN → DRAIN when `run_i`=0.
- Pause:
  - `pause_en_o` is the registered `pause_req_i` in RUN, forced 0 in every other state.
  - `pause_polarity_o` is captured from `pause_polarity_i` only while `pause_en_o`=0. It is stable for the whole pause.
- Violations: any cycle with either violation input high sets `violation_sticky_o`. Both inputs high in the same cycle counts once.

## Timing
- Handshake sampled at edge k. The state is CHECK in cycle k+1 (`cfg_reject_o` goes high here if invalid). ARM is in cycle k+2: new rate outputs and `set_polarity_o` appear together. `generation_en_o` goes high in cycle k+3.
- From RUN, the reconfiguration latency is 2 + the generator drain time. The rate outputs never change while `gen_busy_i`=1.
- `clk_en`=0 freezes the FSM, the registers and the pulse outputs. `set_polarity_o` and `cfg_reject_o` stay asserted until the next enabled edge.
- Clear and a new violation in the same cycle: the event wins. Sticky=1 and count=1.
- The counter saturates at 2^VW−1.
- Asynchronous reset mid-sequence: immediate IDLE, outputs to reset values, shadow and applied configuration discarded.

## Configuration
- `GEN_SEQ_VIOLATION_COUNT_EN` defined: `violation_count_o` counts violation cycles as specified above.
- `GEN_SEQ_VIOLATION_COUNT_EN` undefined: no counter logic, `violation_count_o` is tied to 0, and only the sticky flag is kept.

## Test plan
- Valid config from IDLE (half=20, lead=5, offset=4, polarity 1, `run_i`=1) -> outputs 19/9/14/4/4 and `set_polarity_o` pulse in cycle k+2; `generation_en_o`=1 in cycle k+3.
- Invalid config (half=9, lead=5, offset=4) -> `cfg_reject_o` one cycle in k+1; outputs and state unchanged, both from IDLE and from RUN.
- Reconfigure in RUN with `gen_busy_i` held 6 cycles after enable drops -> `generation_en_o`=0, rates unchanged until busy falls, then ARM pulse and return to RUN.
- `pause_req_i` toggled in IDLE and in RUN, with `pause_polarity_i` flipped mid-pause -> `pause_en_o` only in RUN, one cycle late; `pause_polarity_o` holds its captured value.
- 300 violation cycles with VW=8, then clear plus a violation in the same cycle -> count=255 (macro on) or 0 (macro off); after the clear, count=1 and sticky=1.
- `rst_n` asserted during DRAIN and again during ARM -> immediate IDLE, all outputs 0, `configured_o`=0.
